acc_tile_buffer: RTL and testbench
==================================

// Module: acc_tile_buffer
// PURPOSE
//  Per-column psum accumulation buffer behind the systolic array. Generalises the FIFO accumulator with:
//  - explicit row addressing and a programmable K-pass count
//  - a wider accumulator
//  - a valid/ready drain port to GLB
//  Sits between SA psum outputs and the GLB write path; one tile = cfg_rows rows x PE_SIZE columns, summed over cfg_passes.
// PARAMETERS
//  PE_SIZE     16  number of columns (one accumulator column per SA column)
//  DATA_WIDTH  32  psum input width, signed
//  ACC_WIDTH   40  accumulator/output width, signed; must be >= DATA_WIDTH
//  DEPTH       64  entries per column (max cfg_rows)
//  PASS_W       8  width of cfg_passes
// PORTS
//  clk            in   1                   clock, all logic on rising edge
//  rst            in   1                   synchronous, active-high reset
//  cfg_start_i    in   1                   start tile; sampled only in IDLE
//  cfg_rows_i     in   $clog2(DEPTH+1)     rows per pass, legal 1..DEPTH
//  cfg_passes_i   in   PASS_W              passes per tile, legal >=1
//  psum_en_i      in   PE_SIZE             per-column psum valid (columns skewed)
//  psum_row_i     in   DATA_WIDTH*PE_SIZE  column j at [DATA_WIDTH*(PE_SIZE-j)-1 -: DATA_WIDTH]
//  out_valid_o    out  1                   drain row valid
//  out_ready_i    in   1                   GLB accepts drain row
//  out_row_o      out  ACC_WIDTH*PE_SIZE   drained row, same column packing as input
//  busy_o         out  1                   high in ACCUM or DRAIN
//  done_o         out  1                   one-cycle pulse on last drain handshake
//  err_o          out  1                   sticky: illegal cfg or unexpected psum_en; cleared by rst or accepted start
// BEHAVIOUR
//  Reset: state=IDLE; all pointers, pass counters and col_done cleared; out_valid_o, busy_o, done_o, err_o = 0. Memory contents are not reset.
//  FSM IDLE -> ACCUM -> DRAIN -> IDLE.
//  IDLE:
//   - cfg_start_i with legal cfg: latch rows/passes, clear err_o, enter ACCUM next cycle.
//   - Illegal cfg (rows=0, rows>DEPTH, passes=0): stay IDLE, set err_o.
//  ACCUM, per column j, on psum_en_i[j] && !col_done[j]:
//   - pass_cnt[j]==0: mem[j][wp[j]] <= sext(psum_j).
//   - Otherwise: mem[j][wp[j]] <= mem[j][wp[j]] + sext(psum_j). Wraps mod 2^ACC_WIDTH unless ACC_SAT_EN.
//   - wp[j]==rows-1: wp[j] <= 0, pass_cnt[j]++. If this was the last pass, col_done[j] <= 1.
//   - Otherwise: wp[j]++.
//  Columns advance independently; one write per column per cycle, single-cycle read-modify-write.
//  ACCUM -> DRAIN the cycle after all col_done bits are 1. out_valid_o rises in that DRAIN cycle, so the first drain row is valid 1 cycle after the final column write.
//  DRAIN:
//   - out_row_o = {mem[j][rp]} for all j.
//   - out_valid_o && out_ready_i: rp++. At rp==rows-1: done_o pulse, out_valid_o=0, IDLE next cycle.
//   - out_valid_o && !out_ready_i: out_row_o and rp held stable.
//  psum_en_i bit set while IDLE, in DRAIN, or on a done column: write ignored, err_o set.
//  cfg_start_i outside IDLE: ignored, no error.
//  rst mid-ACCUM/DRAIN: abort to IDLE next cycle; partial sums are discarded logically.
// CONFIGURATION
//  ACC_SAT_EN defined: the accumulate and the first-pass sign-extend saturate to signed ACC_WIDTH limits [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
//  ACC_SAT_EN undefined: two's-complement wrap. No other behaviour differs.
// STRUCTURE
//  Shared package tpu_acc_pkg: FSM state encoding (IDLE/ACCUM/DRAIN); saturating-add function; column slice index helper.
//  Sub-module acc_column, one instance per column: memory array, wp, pass_cnt, col_done, adder/saturation.
//  Top level: FSM, drain pointer rp, cfg latch, err/done logic, output packing.
// TESTING  (PE_SIZE=4, DATA_WIDTH=8, ACC_WIDTH=16, DEPTH=8 unless noted)
//  1 rows=4, passes=1, all columns write psum 1,2,3,4 on the same cycles, ready=1
//    -> 4 drain rows 0x0001..0x0004 in every column, done_o pulse, busy_o=0 after.
//  2 rows=3, passes=3, column j skewed j cycles, psum=5 always
//    -> every drained entry 15; first out_valid_o 1 cycle after column 3's last write.
//  3 Scenario 1 with out_ready_i low 3 cycles after the 2nd row
//    -> row 2 held constant 3 cycles, no row skipped or duplicated.
//  4 rows=2, passes=2, psum=0xFF (-1) -> drained 0xFFFE.
//    Pass-0 psum=0x80 (-128) -> drained 0xFF80 (sign extension).
//  5 DATA_WIDTH=ACC_WIDTH=16, passes=2, psum 0x7FFF then 0x0001
//    -> 0x7FFF with ACC_SAT_EN defined; 0x8000 without.
//  6 a) rst mid-ACCUM, then new start rows=2, passes=1, psum 7
//       -> drains 7, no stale data; busy_o=0 and err_o=0 right after the reset.
//    b) psum_en_i in IDLE, or cfg_rows=0 -> err_o=1, state stays IDLE.

Source files
------------

// File: rtl/tpu_acc_pkg.sv
// Shared definitions for the accumulation tile buffer: FSM state encoding,
// column slice helper and a width-generic saturating adder.
package tpu_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } acc_state_e;

    // Widest accumulator the saturating adder supports.
    localparam int SAT_W = 64;

    // LSB of column 'col' in a bus where column 0 occupies the top slice.
    function automatic int col_lsb(input int col, input int width, input int n_cols);
        return width * (n_cols - 1 - col);
    endfunction

    // Signed add of two sign-extended operands, clamped to a 'width'-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             width
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        logic signed [SAT_W:0] one;
        one = {{SAT_W{1'b0}}, 1'b1};
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = (one <<< (width - 1)) - one;
        lo  = -(one <<< (width - 1));
        if (sum > hi) begin
            return hi[SAT_W-1:0];
        end else if (sum < lo) begin
            return lo[SAT_W-1:0];
        end else begin
            return sum[SAT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/acc_column.sv
// One accumulator column: row memory, write pointer, pass counter and done flag.
// Define ACC_SAT_EN to saturate the accumulate instead of wrapping.
module acc_column
    import tpu_acc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int DEPTH      = 64,
    parameter int PASS_W     = 8,
    parameter int ROW_W      = $clog2(DEPTH + 1),
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_psum,
    input  logic [ROW_W-1:0]      i_rows,
    input  logic [PASS_W-1:0]     i_passes,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [ACC_WIDTH-1:0]  o_rd_data,
    output logic                  o_col_done
);

    logic [ACC_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]    r_wp;
    logic [PASS_W-1:0]    r_pass_cnt;
    logic                 r_col_done;

    logic                        w_wr;
    logic                        w_first_pass;
    logic                        w_last_row;
    logic                        w_last_pass;
    logic signed [ACC_WIDTH-1:0] w_ext;
    logic signed [ACC_WIDTH-1:0] w_old;
    logic signed [ACC_WIDTH-1:0] w_new;

    assign w_wr         = i_en & ~r_col_done & ~rst;
    assign w_first_pass = (r_pass_cnt == '0);
    assign w_last_row   = (ROW_W'(r_wp) == i_rows - ROW_W'(1));
    assign w_last_pass  = (r_pass_cnt == i_passes - PASS_W'(1));
    assign w_ext        = ACC_WIDTH'($signed(i_psum));
    assign w_old        = r_mem[r_wp];

`ifdef ACC_SAT_EN
    logic signed [SAT_W-1:0] w_sat;
    assign w_sat = sat_add(SAT_W'(w_ext), w_first_pass ? '0 : SAT_W'(w_old), ACC_WIDTH);
    assign w_new = w_sat[ACC_WIDTH-1:0];
`else
    // The first pass overwrites, so stale contents never leak into a new tile.
    assign w_new = w_first_pass ? w_ext : w_ext + w_old;
`endif

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wp       <= '0;
            r_pass_cnt <= '0;
            r_col_done <= 1'b0;
        end else if (w_wr) begin
            if (w_last_row) begin
                r_wp       <= '0;
                r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                if (w_last_pass) begin
                    r_col_done <= 1'b1;
                end
            end else begin
                r_wp <= r_wp + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= w_new;
        end
    end

    assign o_rd_data  = r_mem[i_rd_addr];
    assign o_col_done = r_col_done;

endmodule

// File: rtl/acc_tile_buffer.sv
// Per-column psum accumulation buffer with row addressing, K-pass count and a
// valid/ready drain port. Define ACC_SAT_EN for saturating accumulation.
module acc_tile_buffer
    import tpu_acc_pkg::*;
#(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 40,
    parameter int DEPTH      = 64,
    parameter int PASS_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_start_i,
    input  logic [$clog2(DEPTH+1)-1:0]    cfg_rows_i,
    input  logic [PASS_W-1:0]             cfg_passes_i,
    input  logic [PE_SIZE-1:0]            psum_en_i,
    input  logic [DATA_WIDTH*PE_SIZE-1:0] psum_row_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [ACC_WIDTH*PE_SIZE-1:0]  out_row_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int ROW_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = $clog2(DEPTH);

    acc_state_e        r_state;
    logic [ROW_W-1:0]  r_rows;
    logic [PASS_W-1:0] r_passes;
    logic [ADDR_W-1:0] r_rp;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [PE_SIZE-1:0] w_col_en;
    logic [PE_SIZE-1:0] w_col_done;
    logic [PE_SIZE-1:0] w_col_active;
    logic               w_cfg_ok;
    logic               w_start;
    logic               w_cfg_bad;
    logic               w_bad_en;
    logic               w_hs;
    logic               w_last_rd;

    assign w_cfg_ok  = (cfg_rows_i != '0) && (cfg_rows_i <= ROW_W'(DEPTH)) && (cfg_passes_i != '0);
    assign w_start   = (r_state == ST_IDLE) && cfg_start_i && w_cfg_ok;
    assign w_cfg_bad = (r_state == ST_IDLE) && cfg_start_i && !w_cfg_ok;

    // A psum is only welcome on a column that is still accumulating.
    assign w_col_active = (r_state == ST_ACCUM) ? ~w_col_done : '0;
    assign w_col_en     = psum_en_i & {PE_SIZE{r_state == ST_ACCUM}};
    assign w_bad_en     = |(psum_en_i & ~w_col_active);

    assign w_hs      = r_out_valid & out_ready_i;
    assign w_last_rd = (ROW_W'(r_rp) == r_rows - ROW_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < PE_SIZE; gi++) begin : g_col
            localparam int IN_LSB  = col_lsb(gi, DATA_WIDTH, PE_SIZE);
            localparam int OUT_LSB = col_lsb(gi, ACC_WIDTH, PE_SIZE);

            acc_column #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .DEPTH      (DEPTH),
                .PASS_W     (PASS_W),
                .ROW_W      (ROW_W),
                .ADDR_W     (ADDR_W)
            ) u_col (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (w_start),
                .i_en       (w_col_en[gi]),
                .i_psum     (psum_row_i[IN_LSB +: DATA_WIDTH]),
                .i_rows     (r_rows),
                .i_passes   (r_passes),
                .i_rd_addr  (r_rp),
                .o_rd_data  (out_row_o[OUT_LSB +: ACC_WIDTH]),
                .o_col_done (w_col_done[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rows      <= '0;
            r_passes    <= '0;
            r_rp        <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cfg_bad || w_bad_en) begin
                r_err <= 1'b1;
            end else if (w_start) begin
                r_err <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_rows   <= cfg_rows_i;
                        r_passes <= cfg_passes_i;
                        r_rp     <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (&w_col_done) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_hs) begin
                        if (w_last_rd) begin
                            r_rp        <= '0;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_rp <= r_rp + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid_o = r_out_valid;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_acc_tile_buffer.sv
// Scoreboard bench for acc_tile_buffer: directed tiles push expected drain rows,
// independent monitors pop and compare on every drain handshake.
module tb_acc_tile_buffer;

    localparam int PE    = 4;
    localparam int DW    = 8;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int PW    = 8;
    localparam int RW    = $clog2(DEPTH + 1);
    localparam int PE2    = 2;
    localparam int DW2    = 16;
    localparam int DEPTH2 = 4;
    localparam int RW2    = $clog2(DEPTH2 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cfg_start;
    logic [RW-1:0]     cfg_rows;
    logic [PW-1:0]     cfg_passes;
    logic [PE-1:0]     psum_en;
    logic [PE*DW-1:0]  psum_row;
    logic              out_valid;
    logic              out_ready;
    logic [PE*AW-1:0]  out_row;
    logic              busy;
    logic              done;
    logic              err;

    logic              d2_start;
    logic [RW2-1:0]    d2_rows;
    logic [PW-1:0]     d2_passes;
    logic [PE2-1:0]    d2_en;
    logic [PE2*DW2-1:0] d2_row;
    logic              d2_valid;
    logic              d2_ready;
    logic [PE2*DW2-1:0] d2_out;
    logic              d2_busy;
    logic              d2_done;
    logic              d2_err;

    acc_tile_buffer #(
        .PE_SIZE(PE), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .DEPTH(DEPTH), .PASS_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start_i(cfg_start), .cfg_rows_i(cfg_rows),
        .cfg_passes_i(cfg_passes), .psum_en_i(psum_en), .psum_row_i(psum_row),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // Accumulator as wide as the input, so the wrap/saturate boundary is reachable.
    acc_tile_buffer #(
        .PE_SIZE(PE2), .DATA_WIDTH(DW2), .ACC_WIDTH(DW2), .DEPTH(DEPTH2), .PASS_W(PW)
    ) dut2 (
        .clk(clk), .rst(rst), .cfg_start_i(d2_start), .cfg_rows_i(d2_rows),
        .cfg_passes_i(d2_passes), .psum_en_i(d2_en), .psum_row_i(d2_row),
        .out_valid_o(d2_valid), .out_ready_i(d2_ready), .out_row_o(d2_out),
        .busy_o(d2_busy), .done_o(d2_done), .err_o(d2_err)
    );

    int    n_checks  = 0;
    int    n_errors  = 0;
    int    done_cnt  = 0;
    string test_name = "reset";
    logic [PE*AW-1:0]   exp_q[$];
    logic [PE2*DW2-1:0] exp2_q[$];

    task automatic check(input string what, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s/%s: got %0h, expected %0h", test_name, what, act, req);
        end
    endtask

    // Main drain monitor: pop on handshake, verify hold while stalled.
    logic [PE*AW-1:0] prev_row;
    logic [PE*AW-1:0] exp_row;
    bit               prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_hold", 64'(out_row), 64'(prev_row));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s/extra_row: got %h, expected no row", test_name, out_row);
                end else begin
                    exp_row = exp_q.pop_front();
                    $display("[%0t] %s drain row=%h expected=%h", $time, test_name, out_row, exp_row);
                    check("drain_row", 64'(out_row), 64'(exp_row));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_row   = out_row;
        end
    end

    logic [PE2*DW2-1:0] exp2_row;
    always @(negedge clk) begin
        if (!rst && d2_valid && d2_ready) begin
            if (exp2_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s/extra_row2: got %h, expected no row", test_name, d2_out);
            end else begin
                exp2_row = exp2_q.pop_front();
                $display("[%0t] %s drain2 row=%h expected=%h", $time, test_name, d2_out, exp2_row);
                check("drain_row2", 64'(d2_out), 64'(exp2_row));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int rows, input int passes);
        cfg_rows   = RW'(rows);
        cfg_passes = PW'(passes);
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
    endtask

    task automatic write(input logic [PE-1:0] en, input logic [PE*DW-1:0] row);
        psum_en  = en;
        psum_row = row;
        tick();
        psum_en  = '0;
    endtask

    task automatic wait_done(input int exp_done);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s/timeout: busy_o still 1 after %0d cycles, required 0", test_name, n);
        end
        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'(exp_done));
        check("busy_low", 64'(busy), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [PE-1:0] en;
        rst = 1'b1; cfg_start = 1'b0; cfg_rows = '0; cfg_passes = '0;
        psum_en = '0; psum_row = '0; out_ready = 1'b1;
        d2_start = 1'b0; d2_rows = '0; d2_passes = '0; d2_en = '0; d2_row = '0; d2_ready = 1'b1;
        repeat (2) tick();
        check("valid", 64'(out_valid), 64'd0);
        check("busy", 64'(busy), 64'd0);
        check("done", 64'(done), 64'd0);
        check("err", 64'(err), 64'd0);
        check("busy2", 64'(d2_busy), 64'd0);
        rst = 1'b0;
        tick();

        test_name = "t1_basic";
        for (int v = 1; v <= 4; v++) exp_q.push_back({PE{AW'(v)}});
        start(4, 1);
        for (int v = 1; v <= 4; v++) write('1, {PE{DW'(v)}});
        wait_done(1);

        test_name = "t2_skew";
        repeat (3) exp_q.push_back({PE{16'd15}});
        start(3, 3);
        for (int t = 0; t < 12; t++) begin
            en = '0;
            for (int j = 0; j < PE; j++) en[j] = (t >= j) && (t < j + 9);
            write(en, {PE{8'd5}});
        end
        check("valid_not_yet", 64'(out_valid), 64'd0);
        tick();
        check("valid_rises", 64'(out_valid), 64'd1);
        wait_done(2);

        test_name = "t3_stall";
        for (int v = 1; v <= 4; v++) exp_q.push_back({PE{AW'(v)}});
        start(4, 1);
        for (int v = 1; v <= 4; v++) write('1, {PE{DW'(v)}});
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
        wait_done(3);

        test_name = "t4_sign";
        exp_q.push_back({PE{16'hFFFE}});
        exp_q.push_back({16'hFF80, 16'hFF00, 16'h00FE, 16'h0000});
        start(2, 2);
        write('1, {PE{8'hFF}});
        write('1, {8'h80, 8'h80, 8'h7F, 8'h01});
        write('1, {PE{8'hFF}});
        write('1, {8'h00, 8'h80, 8'h7F, 8'hFF});
        wait_done(4);

        test_name = "t5_sat";
`ifdef ACC_SAT_EN
        exp2_q.push_back({16'h7FFF, 16'h8000});
`else
        exp2_q.push_back({16'h8000, 16'h7FFF});
`endif
        d2_rows = RW2'(1); d2_passes = PW'(2); d2_start = 1'b1;
        tick();
        d2_start = 1'b0;
        d2_en = '1; d2_row = {16'h7FFF, 16'h8000};
        tick();
        d2_row = {16'h0001, 16'hFFFF};
        tick();
        d2_en = '0;
        n = 0;
        while (d2_busy && n < 50) begin
            tick();
            n++;
        end
        tick();
        check("queue2_empty", 64'(exp2_q.size()), 64'd0);
        check("busy2_low", 64'(d2_busy), 64'd0);
        check("err2", 64'(d2_err), 64'd0);

        test_name = "t6a_reset";
        start(4, 2);
        write('1, {PE{8'd9}});
        write('1, {PE{8'd9}});
        rst = 1'b1;
        tick();
        check("busy_after_rst", 64'(busy), 64'd0);
        check("err_after_rst", 64'(err), 64'd0);
        check("valid_after_rst", 64'(out_valid), 64'd0);
        rst = 1'b0;
        repeat (2) exp_q.push_back({PE{16'd7}});
        start(2, 1);
        write('1, {PE{8'd7}});
        write('1, {PE{8'd7}});
        wait_done(5);

        test_name = "t6b_err";
        write(4'b0001, {PE{8'h11}});
        check("err_idle_en", 64'(err), 64'd1);
        check("idle_stays", 64'(busy), 64'd0);
        start(1, 1);
        check("err_cleared_by_start", 64'(err), 64'd0);
        exp_q.push_back({PE{16'h0003}});
        write('1, {PE{8'h03}});
        write(4'b0010, {PE{8'h55}});
        check("err_done_col", 64'(err), 64'd1);
        wait_done(6);
        check("err_sticky", 64'(err), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("err_rst_clear", 64'(err), 64'd0);
        start(0, 1);
        check("err_rows0", 64'(err), 64'd1);
        tick();
        check("rows0_idle", 64'(busy), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        start(9, 1);
        check("err_rows_big", 64'(err), 64'd1);
        check("rows_big_idle", 64'(busy), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        start(2, 0);
        check("err_passes0", 64'(err), 64'd1);
        check("passes0_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
